// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the load/store stage
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_BUSERR   = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Natural alignment; a doubleword also faults on a 32-bit datapath.
  function automatic logic addr_misaligned(input logic [1:0] size,
                                           input logic [2:0] addr_lo,
                                           input logic       xlen64);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = |addr_lo[1:0];
      default: bad = (|addr_lo) || !xlen64;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - op, result and data-bus signals of the load/store stage
interface mem_access_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_load;
  logic              in_is_store;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_exc;
  logic [1:0]        out_exc_code;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_mode;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_wstrb;
  logic              bus_resp_valid;
  logic [XLEN-1:0]   bus_resp_data;
  logic              bus_resp_err;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_size, in_unsigned, in_addr, in_wdata, in_tag,
    input  out_ready, bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_err,
    output in_ready, out_valid, out_result, out_tag, out_exc, out_exc_code,
    output bus_req_valid, bus_mode, bus_addr, bus_wdata, bus_wstrb
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_size, in_unsigned, in_addr, in_wdata, in_tag,
    output out_ready, bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_err,
    input  in_ready, out_valid, out_result, out_tag, out_exc, out_exc_code,
    input  bus_req_valid, bus_mode, bus_addr, bus_wdata, bus_wstrb
  );

endinterface

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - store lane/strobe placement and load field extract/extend
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]       st_size,
  input  logic [OFF_W-1:0] st_off,
  input  logic [XLEN-1:0]  st_src,
  output logic [XLEN-1:0]  st_data,
  output logic [NB-1:0]    st_strb,
  input  logic [1:0]       ld_size,
  input  logic [OFF_W-1:0] ld_off,
  input  logic             ld_unsigned,
  input  logic [XLEN-1:0]  ld_raw,
  output logic [XLEN-1:0]  ld_data
);

  function automatic logic [NB-1:0] size_lanes(input logic [1:0] size);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << size)) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [NB-1:0]   ld_lanes;
  logic [XLEN-1:0] st_shift;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_mask;
  logic            ld_sign;

  always_comb begin
    st_strb  = size_lanes(st_size) << st_off;
    st_shift = st_src << {st_off, 3'b000};
    ld_shift = ld_raw >> {ld_off, 3'b000};
    ld_lanes = size_lanes(ld_size);
    st_data  = '0;
    ld_mask  = '0;
    // Lanes outside the strobe go out as zero so the bus never sees stale rs2 bytes.
    for (int i = 0; i < NB; i++) begin
      st_data[8*i +: 8] = st_strb[i] ? st_shift[8*i +: 8] : 8'h00;
      ld_mask[8*i +: 8] = {8{ld_lanes[i]}};
    end
    case (ld_size)
      SZ_B:    ld_sign = ld_shift[7];
      SZ_H:    ld_sign = ld_shift[15];
      SZ_W:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[XLEN-1];
    endcase
    ld_data = (ld_shift & ld_mask) | ((ld_sign && !ld_unsigned) ? ~ld_mask : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage issuing one aligned bus word per op
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave io
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  mem_state_e       state;
  mem_state_e       state_nxt;

  logic             op_load;
  logic             op_unsigned;
  logic [1:0]       op_size;
  logic [OFF_W-1:0] op_off;
  logic [TAG_W-1:0] tag_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [XLEN-1:0]  bus_addr_q;
  logic [XLEN-1:0]  bus_wdata_q;
  logic [NB-1:0]    bus_wstrb_q;
  logic             bus_mode_q;
  logic [XLEN-1:0]  out_result_q;
  logic [1:0]       exc_code_q;

  logic             accept;
  logic             is_mem;
  logic             misaligned;
  logic             tmo_hit;
  logic             resp_take;
  logic             tmo_take;
  logic [XLEN-1:0]  st_data;
  logic [NB-1:0]    st_strb;
  logic [XLEN-1:0]  ld_data;

  mem_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
    .st_size     (io.in_size),
    .st_off      (io.in_addr[OFF_W-1:0]),
    .st_src      (io.in_wdata),
    .st_data     (st_data),
    .st_strb     (st_strb),
    .ld_size     (op_size),
    .ld_off      (op_off),
    .ld_unsigned (op_unsigned),
    .ld_raw      (io.bus_resp_data),
    .ld_data     (ld_data)
  );

  assign accept     = io.in_valid && (state == ST_IDLE);
  assign is_mem     = io.in_is_load || io.in_is_store;
  assign misaligned = addr_misaligned(io.in_size, io.in_addr[2:0], XLEN == 64);
  // ">=" keeps the limit effective if the request is taken on the limit cycle.
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt >= TMO_W'(TIMEOUT - 1));
  assign resp_take  = (state == ST_RESP) && io.bus_resp_valid;
  assign tmo_take   = tmo_hit && (((state == ST_REQ) && !io.bus_req_ready) ||
                                  ((state == ST_RESP) && !io.bus_resp_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (is_mem && !misaligned) ? ST_REQ : ST_DONE;
      ST_REQ: begin
        if (io.bus_req_ready) state_nxt = ST_RESP;
        else if (tmo_take)    state_nxt = ST_DONE;
      end
      ST_RESP: if (resp_take || tmo_take) state_nxt = ST_DONE;
      ST_DONE: if (io.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready      = (state == ST_IDLE);
    io.out_valid     = (state == ST_DONE);
    io.bus_req_valid = (state == ST_REQ);
    io.out_exc       = (state == ST_DONE) && (exc_code_q != EXC_NONE);
    io.out_exc_code  = exc_code_q;
    io.out_result    = out_result_q;
    io.out_tag       = tag_q;
    io.bus_mode      = bus_mode_q;
    io.bus_addr      = bus_addr_q;
    io.bus_wdata     = bus_wdata_q;
    io.bus_wstrb     = bus_wstrb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_load      <= 1'b0;
      op_unsigned  <= 1'b0;
      op_size      <= SZ_B;
      op_off       <= '0;
      tag_q        <= '0;
      tmo_cnt      <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      bus_mode_q   <= MEMREQ_READ;
      out_result_q <= '0;
      exc_code_q   <= EXC_NONE;
    end else if (accept) begin
      op_load      <= io.in_is_load;
      op_unsigned  <= io.in_unsigned;
      op_size      <= io.in_size;
      op_off       <= io.in_addr[OFF_W-1:0];
      tag_q        <= io.in_tag;
      tmo_cnt      <= '0;
      out_result_q <= '0;
      exc_code_q   <= (is_mem && misaligned) ? EXC_MISALIGN : EXC_NONE;
      if (is_mem && !misaligned) begin
        bus_mode_q  <= io.in_is_store ? MEMREQ_WRITE : MEMREQ_READ;
        bus_addr_q  <= io.in_addr & ~XLEN'(NB - 1);
        bus_wdata_q <= io.in_is_store ? st_data : '0;
        bus_wstrb_q <= io.in_is_store ? st_strb : '0;
      end
    end else if ((state == ST_REQ) || (state == ST_RESP)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (resp_take) begin
        exc_code_q   <= io.bus_resp_err ? EXC_BUSERR : EXC_NONE;
        out_result_q <= (op_load && !io.bus_resp_err) ? ld_data : '0;
      end else if (tmo_take) begin
        exc_code_q   <= EXC_TIMEOUT;
        out_result_q <= '0;
      end
    end
  end

endmodule
